// File: rtl/sonar_echo_emulator_pkg.sv
// Shared types and constants for the sonar echo emulator.
// States, register addresses and control bit positions.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  localparam logic ADDR_CTRL  = 1'b0;
  localparam logic ADDR_WIDTH = 1'b1;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int STAT_EN    = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_SHORT = 2;

endpackage

// File: rtl/sonar_echo_emulator_if.sv
// CPU register bus of the sonar echo emulator.
// master = CPU side, slave = emulator side.
interface sonar_echo_emulator_if;

  logic        addr;
  logic        write;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output addr,
    output write,
    output write_data,
    input  read_data
  );

  modport slave (
    input  addr,
    input  write,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/sonar_echo_emulator_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
// Used for the asynchronous trigger input.
module sonar_sync2 (
  input  logic clk,
  input  logic reset_all,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sonar_echo_emulator.sv
// Ultrasonic sensor stand-in: qualifies trigger, then drives a programmed echo.
// Define SONAR_EMU_TIMEOUT_EN to make a zero width emit a TIMEOUT_CYCLES echo.
module sonar_echo_emulator
  import sonar_pkg::*;
#(
  parameter int COUNT_WIDTH     = 32,
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int BURST_CYCLES    = 400,
  parameter int HOLDOFF_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES  = 1900000
) (
  input  logic                   clk,
  input  logic                   reset_all,
  sonar_echo_emulator_if.slave   bus,
  input  logic                   trigger,
  output logic                   echo
);

  localparam logic [COUNT_WIDTH-1:0] TRIG_LOAD =
    COUNT_WIDTH'(MIN_TRIG_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] BURST_LOAD =
    COUNT_WIDTH'(BURST_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] HOLD_LOAD =
    COUNT_WIDTH'(HOLDOFF_CYCLES - 1);

  if (MIN_TRIG_CYCLES < 1 || BURST_CYCLES < 1 ||
      HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      COUNT_WIDTH > 32) begin : g_bad_param
    $error("sonar_echo_emulator: bad parameter");
  end

  state_t                 state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] shadow;
  logic [COUNT_WIDTH-1:0] echo_width;
  logic                   enable;
  logic                   trig_short;
  logic                   need_low;
  logic                   trig_s;
  logic                   short_det;
  logic                   wr_ctrl;
  logic                   wr_width;

  sonar_sync2 u_sync (
    .clk       (clk),
    .reset_all (reset_all),
    .d         (trigger),
    .q         (trig_s)
  );

  assign wr_ctrl  = bus.write && (bus.addr == ADDR_CTRL);
  assign wr_width = bus.write && (bus.addr == ADDR_WIDTH);

  assign short_det = (state == TRIG) && enable &&
                     !trig_s && (cnt != '0);

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      enable     <= 1'b0;
      trig_short <= 1'b0;
      echo_width <= '0;
      bus.read_data <= '0;
    end else begin
      if (wr_ctrl) enable <= bus.write_data[CTRL_EN];
      if (wr_width) echo_width <= bus.write_data[COUNT_WIDTH-1:0];
      // a new short detection beats a same-cycle clear
      if (short_det)
        trig_short <= 1'b1;
      else if (wr_ctrl && bus.write_data[CTRL_CLR])
        trig_short <= 1'b0;
      if (bus.addr == ADDR_WIDTH) begin
        bus.read_data <= 32'(echo_width);
      end else begin
        bus.read_data             <= '0;
        bus.read_data[STAT_EN]    <= enable;
        bus.read_data[STAT_BUSY]  <= (state != IDLE);
        bus.read_data[STAT_SHORT] <= trig_short;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      need_low <= 1'b0;
      echo     <= 1'b0;
    end else if (state != IDLE && !enable) begin
      state    <= IDLE;
      echo     <= 1'b0;
      need_low <= trig_s;
    end else begin
      unique case (state)
        IDLE: begin
          echo <= 1'b0;
          if (!trig_s) need_low <= 1'b0;
          if (enable && trig_s && !need_low) begin
            state <= TRIG;
            cnt   <= TRIG_LOAD;
          end
        end
        TRIG: begin
          if (trig_s) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
          end else if (cnt == '0) begin
            shadow <= echo_width;
            state  <= BURST;
            cnt    <= BURST_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (shadow == '0) begin
`ifdef SONAR_EMU_TIMEOUT_EN
            state <= ECHO;
            echo  <= 1'b1;
            cnt   <= COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
`else
            state <= HOLDOFF;
            cnt   <= HOLD_LOAD;
`endif
          end else begin
            state <= ECHO;
            echo  <= 1'b1;
            cnt   <= shadow - 1'b1;
          end
        end
        ECHO: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= HOLDOFF;
            echo  <= 1'b0;
            cnt   <= HOLD_LOAD;
          end
        end
        HOLDOFF: begin
          // a trigger still high here must fall before it can count again
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state    <= IDLE;
            need_low <= trig_s;
          end
        end
        default: begin
          state <= IDLE;
          echo  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// Directed bench for sonar_echo_emulator with hand-computed expectations.
// Trigger fall to echo rise is BURST+1 after trig_s, plus 2 sync flops.
module tb_sonar_echo_emulator;

  localparam int RISE = 400 + 1 + 2;

  logic clk       = 1'b0;
  logic reset_all = 1'b0;
  logic trigger   = 1'b0;
  logic echo;

  int n_chk  = 0;
  int n_fail = 0;

  sonar_echo_emulator_if bus ();

  sonar_echo_emulator dut (
    .clk       (clk),
    .reset_all (reset_all),
    .bus       (bus.slave),
    .trigger   (trigger),
    .echo      (echo)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus.addr       = a;
    bus.write_data = d;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    @(negedge clk);
    bus.addr = a;
    @(posedge clk);
    #1 v = bus.read_data;
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    trigger = 1'b1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic rise_delay(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!echo && n < 3000);
  endtask

  task automatic hi_width(output int w);
    w = 0;
    do begin
      @(posedge clk);
      w++;
      #1;
    end while (echo && w < 5000);
  endtask

  task automatic quiet(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1 if (echo) seen = 1;
    end
  endtask

  initial begin
    logic [31:0] v;
    int d;
    int w;
    int s;

    bus.addr       = 1'b0;
    bus.write      = 1'b0;
    bus.write_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_echo", 32'(echo), 0);
    reset_all = 1'b1;
    rd(1'b0, v); chk("reset_ctrl", v, 0);
    rd(1'b1, v); chk("reset_width", v, 0);

    wr(1'b0, 32'h1);
    wr(1'b1, 32'd1000);
    rd(1'b1, v); chk("width_rb", v, 1000);
    rd(1'b0, v); chk("ctrl_en", v, 1);

    pulse(500);
    rise_delay(d); chk("rise_500", 32'(d), RISE);
    hi_width(w); chk("width_1000", 32'(w), 1000);
    rd(1'b0, v); chk("busy_holdoff", v, 3);
    repeat (1100) @(negedge clk);
    rd(1'b0, v); chk("idle_after", v, 1);

    pulse(499);
    quiet(500, s); chk("short_noecho", 32'(s), 0);
    rd(1'b0, v); chk("short_flag", v, 5);
    wr(1'b0, 32'h3);
    rd(1'b0, v); chk("short_clear", v, 1);

    pulse(500);
    rise_delay(d); chk("rise_b", 32'(d), RISE);
    fork
      hi_width(w);
      begin
        repeat (100) @(negedge clk);
        wr(1'b1, 32'd50);
      end
    join
    chk("width_inflight", 32'(w), 1000);
    rd(1'b1, v); chk("width_rb50", v, 50);
    repeat (1100) @(negedge clk);
    pulse(500);
    rise_delay(d); chk("rise_c", 32'(d), RISE);
    hi_width(w); chk("width_50", 32'(w), 50);

    pulse(600);
    quiet(1500, s); chk("holdoff_ignore", 32'(s), 0);
    rd(1'b0, v); chk("holdoff_flag", v, 1);

    wr(1'b1, 32'd0);
    pulse(500);
`ifdef SONAR_EMU_TIMEOUT_EN
    rise_delay(d); chk("rise_timeout", 32'(d), RISE);
    repeat (4000) @(negedge clk);
    chk("timeout_high", 32'(echo), 1);
    @(negedge clk);
    reset_all = 1'b0;
    @(negedge clk);
    reset_all = 1'b1;
    wr(1'b0, 32'h1);
`else
    quiet(1600, s); chk("zero_noecho", 32'(s), 0);
    rd(1'b0, v); chk("zero_idle", v, 1);
`endif

    wr(1'b1, 32'd1000);
    pulse(500);
    rise_delay(d); chk("rise_d", 32'(d), RISE);
    repeat (100) @(negedge clk);
    #3 reset_all = 1'b0;
    #1 chk("async_drop", 32'(echo), 0);
    @(negedge clk);
    reset_all = 1'b1;
    rd(1'b0, v); chk("rst_ctrl", v, 0);
    rd(1'b1, v); chk("rst_width", v, 0);
    quiet(20, s); chk("rst_quiet", 32'(s), 0);

    wr(1'b0, 32'h1);
    wr(1'b1, 32'd20);
    pulse(500);
    rise_delay(d); chk("rise_restart", 32'(d), RISE);
    hi_width(w); chk("width_restart", 32'(w), 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
